// File: rtl/mesh_credit_allocator_pkg.sv
// Shared constants, types and helpers for the mesh router switch allocator.
// Port order is core, north, east, south, west.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 4
`endif

package mesh_credit_allocator_pkg;

    localparam int N_PORTS = 5;
    localparam int CREDITS = `FIFO_DEPTH;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int CW = clog2(CREDITS + 1);
    localparam int IW = clog2(N_PORTS);

    typedef enum logic [IW-1:0] {
        CORE  = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef logic [IW-1:0] idx_t;
    typedef logic [CW-1:0] cred_t;

    // (a + k) mod N_PORTS for a < N_PORTS and 0 <= k <= N_PORTS
    function automatic idx_t wrap_add(input idx_t a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N_PORTS) s = s - N_PORTS;
        return idx_t'(s);
    endfunction

endpackage

// File: rtl/mesh_rr_arbiter.sv
// Five-requester round-robin arbiter; the pointer moves past the winner.
// Grants are combinational and only issued while i_en is high.
module mesh_rr_arbiter
    import mesh_credit_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] i_req,
    input  logic               i_en,
    output logic               o_gnt,
    output idx_t               o_idx
);

    idx_t r_ptr;
    idx_t w_cand;
    idx_t w_idx;
    logic w_gnt;

    always_comb begin
        w_gnt  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_cand = wrap_add(r_ptr, k);
            if (i_en && !w_gnt && i_req[w_cand]) begin
                w_gnt = 1'b1;
                w_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= idx_t'(CORE);
        end else if (w_gnt) begin
            r_ptr <= wrap_add(w_idx, 1);
        end
    end

    assign o_gnt = w_gnt;
    assign o_idx = w_idx;

endmodule

// File: rtl/mesh_credit_allocator.sv
// Credit-gated switch allocator: one round-robin arbiter per output,
// zero-latency grants, downstream credit counters and a sticky error flag.
module mesh_credit_allocator
    import mesh_credit_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PORTS-1:0] i_output_req [N_PORTS],
    input  logic [N_PORTS-1:0] i_credit,
    output logic [IW-1:0]      o_sel [N_PORTS],
    output logic [N_PORTS-1:0] o_en,
    output logic [N_PORTS-1:0] o_val,
    output logic               o_err
);

    logic [N_PORTS-1:0] w_elig;
    logic [N_PORTS-1:0] w_bad;
    logic [N_PORTS-1:0] w_col [N_PORTS];
    logic [N_PORTS-1:0] w_gnt;
    logic [N_PORTS-1:0] w_arb_en;
    logic [N_PORTS-1:0] w_sat;
    idx_t               w_idx [N_PORTS];
    cred_t              r_credit [N_PORTS];
    idx_t               r_sel [N_PORTS];
    logic               r_err;

    // Multi-hot vectors are dropped here so they never reach an arbiter
    always_comb begin
        w_elig = '0;
        w_bad  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_elig[i] = $onehot(i_output_req[i]);
            w_bad[i]  = (|i_output_req[i]) && !w_elig[i];
        end
    end

    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            w_col[j] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                w_col[j][i] = w_elig[i] && i_output_req[i][j];
            end
        end
    end

    // Credit seen here is last cycle's count, so a same-cycle return never unblocks
    always_comb begin
        w_arb_en = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            w_arb_en[j] = (r_credit[j] != '0) && !reset;
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_out
        mesh_rr_arbiter u_arb (
            .clk   (clk),
            .reset (reset),
            .i_req (w_col[j]),
            .i_en  (w_arb_en[j]),
            .o_gnt (w_gnt[j]),
            .o_idx (w_idx[j])
        );
    end

    always_comb begin
        w_sat = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            w_sat[j] = i_credit[j] && !w_gnt[j]
                     && (r_credit[j] == cred_t'(CREDITS));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < N_PORTS; j++) begin
                r_credit[j] <= cred_t'(CREDITS);
                r_sel[j]    <= '0;
            end
            r_err <= 1'b0;
        end else begin
            for (int j = 0; j < N_PORTS; j++) begin
                if (w_gnt[j] && !i_credit[j]) begin
                    r_credit[j] <= r_credit[j] - cred_t'(1);
                end else if (!w_gnt[j] && i_credit[j] && !w_sat[j]) begin
                    r_credit[j] <= r_credit[j] + cred_t'(1);
                end
                if (w_gnt[j]) begin
                    r_sel[j] <= w_idx[j];
                end
            end
            r_err <= r_err || (|w_bad) || (|w_sat);
        end
    end

    // One-hot requests guarantee at most one output drives each pop
    always_comb begin
        o_en = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_gnt[j] && (w_idx[j] == idx_t'(i))) begin
                    o_en[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            if (reset) begin
                o_sel[j] = '0;
            end else if (w_gnt[j]) begin
                o_sel[j] = w_idx[j];
            end else begin
                o_sel[j] = r_sel[j];
            end
        end
    end

    assign o_val = w_gnt;
    assign o_err = r_err;

endmodule

// File: tb/tb_mesh_credit_allocator.sv
// Directed bench for the mesh switch allocator with an expectation queue.
// Each step drives inputs after a rising edge and checks on the falling edge.
module tb_mesh_credit_allocator;

    logic       clk;
    logic       reset;
    logic [4:0] req [5];
    logic [4:0] credit;
    logic [2:0] sel [5];
    logic [4:0] en;
    logic [4:0] val;
    logic       err;

    typedef struct {
        string      tag;
        logic [4:0] v;
        logic [4:0] e;
        logic [14:0] s;
        logic       r;
    } exp_t;

    exp_t       q[$];
    logic [2:0] hold [5];
    int         n_chk;
    int         n_pass;

    mesh_credit_allocator dut (
        .clk          (clk),
        .reset        (reset),
        .i_output_req (req),
        .i_credit     (credit),
        .o_sel        (sel),
        .o_en         (en),
        .o_val        (val),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack_sel();
        return {sel[4], sel[3], sel[2], sel[1], sel[0]};
    endfunction

    function automatic logic [14:0] pack_hold();
        return {hold[4], hold[3], hold[2], hold[1], hold[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // gj = granted output (-1 none), gi = granted input
    task automatic cyc(input string tag, input logic [4:0] cr,
                       input int gj, input int gi, input logic eerr);
        exp_t x;
        exp_t y;
        credit = cr;
        if (gj >= 0) hold[gj] = 3'(gi);
        x.tag = tag;
        x.v   = (gj >= 0) ? 5'(1 << gj) : 5'd0;
        x.e   = (gj >= 0) ? 5'(1 << gi) : 5'd0;
        x.s   = pack_hold();
        x.r   = eerr;
        q.push_back(x);
        @(negedge clk);
        y = q.pop_front();
        chk({y.tag, ".val"}, 32'(val), 32'(y.v));
        chk({y.tag, ".en"}, 32'(en), 32'(y.e));
        chk({y.tag, ".sel"}, 32'(pack_sel()), 32'(y.s));
        chk({y.tag, ".err"}, 32'(err), 32'(y.r));
        @(posedge clk);
        #1;
        credit = '0;
    endtask

    task automatic clr_req();
        for (int i = 0; i < 5; i++) req[i] = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        credit = '0;
        clr_req();
        for (int j = 0; j < 5; j++) hold[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.val", 32'(val), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        reset = 1'b0;

        cyc("idle", 5'b0, -1, 0, 1'b0);

        req[1] = 5'b01000;
        cyc("n2s", 5'b0, 3, 1, 1'b0);
        req[2] = 5'b01000;
        cyc("ptr3a", 5'b0, 3, 2, 1'b0);
        req[2] = '0;
        cyc("ptr3b", 5'b0, 3, 1, 1'b0);
        clr_req();

        req[0] = 5'b00010;
        req[2] = 5'b00010;
        req[4] = 5'b00010;
        cyc("rr0", 5'b00010, 1, 0, 1'b0);
        cyc("rr1", 5'b00010, 1, 2, 1'b0);
        cyc("rr2", 5'b00010, 1, 4, 1'b0);
        cyc("rr3", 5'b00010, 1, 0, 1'b0);
        cyc("rr4", 5'b00010, 1, 2, 1'b0);
        cyc("rr5", 5'b00010, 1, 4, 1'b0);
        req[2] = '0;
        req[4] = '0;
        for (int k = 0; k < 4; k++) cyc("cr1", 5'b0, 1, 0, 1'b0);
        cyc("cr1blk", 5'b0, -1, 0, 1'b0);
        clr_req();

        req[2] = 5'b10000;
        for (int k = 0; k < 4; k++) cyc("st4", 5'b0, 4, 2, 1'b0);
        cyc("st4blk", 5'b0, -1, 0, 1'b0);
        cyc("st4ret", 5'b10000, -1, 0, 1'b0);
        cyc("st4one", 5'b0, 4, 2, 1'b0);
        cyc("st4blk2", 5'b0, -1, 0, 1'b0);
        clr_req();

        req[3] = 5'b00110;
        cyc("multi", 5'b0, -1, 0, 1'b0);
        req[3] = '0;
        cyc("errset", 5'b0, -1, 0, 1'b1);
        cyc("errstk", 5'b0, -1, 0, 1'b1);

        req[0] = 5'b00100;
        for (int k = 0; k < 3; k++) cyc("pre", 5'b0, 2, 0, 1'b1);
        req[1] = 5'b00100;
        reset = 1'b1;
        #1;
        chk("arst.val", 32'(val), 32'd0);
        chk("arst.en", 32'(en), 32'd0);
        chk("arst.sel", 32'(pack_sel()), 32'd0);
        chk("arst.err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 5; j++) hold[j] = '0;
        cyc("post0", 5'b0, 2, 0, 1'b0);
        cyc("post1", 5'b0, 2, 1, 1'b0);
        cyc("post2", 5'b0, 2, 0, 1'b0);
        cyc("post3", 5'b0, 2, 1, 1'b0);
        cyc("postblk", 5'b0, -1, 0, 1'b0);
        clr_req();

        cyc("sat", 5'b00001, -1, 0, 1'b0);
        cyc("saterr", 5'b0, -1, 0, 1'b1);
        req[3] = 5'b00001;
        for (int k = 0; k < 4; k++) cyc("satcr", 5'b0, 0, 3, 1'b1);
        cyc("satblk", 5'b0, -1, 0, 1'b1);
        clr_req();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
